// File: rtl/add_sweep_checker_if.sv
// rtl/add_sweep_checker_if.sv - operand/result bus between the sweep checker and the adder under test
//
// Purpose: carries the operand pair out to the combinational adder and its
// sum/carry back to the checker.
// Ports (signals):
//   num1, num2 : operands, driven by the checker (master)
//   sum_in     : adder sum, driven by the adder side (slave)
//   cout_in    : adder carry-out, driven by the adder side (slave)

interface add_sweep_checker_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;

  modport master (
    output num1,
    output num2,
    input  sum_in,
    input  cout_in
  );

  modport slave (
    input  num1,
    input  num2,
    output sum_in,
    output cout_in
  );

endinterface

// File: rtl/add_sweep_checker.sv
// rtl/add_sweep_checker.sv - exhaustive operand sweep and self-check around a WIDTH-bit adder
//
// Purpose: on start, drives every (num1, num2) pair to the adder, one pair per
// clock, compares {cout_in, sum_in} with the golden sum and reports pass/fail,
// the mismatch count and the first failing vector.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : sweep request, honoured only in IDLE
//   bus         : master side of add_sweep_checker_if (num1/num2 out, sum_in/cout_in in)
//   busy        : high from the start edge through the edge that leaves DONE
//   done        : one-cycle pulse in the DONE state
//   pass        : sweep finished with zero mismatches, held until next start
//   err_count   : mismatching vectors in the last sweep
//   first_valid : a mismatch has been captured
//   first_a/b   : operands of the first mismatch
//   first_sum   : sum_in seen at the first mismatch
//   first_cout  : cout_in seen at the first mismatch

module add_sweep_checker #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  add_sweep_checker_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               first_valid,
  output logic [WIDTH-1:0]   first_a,
  output logic [WIDTH-1:0]   first_b,
  output logic [WIDTH-1:0]   first_sum,
  output logic               first_cout
);

  localparam int IDX_W = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH:0]   golden;
  logic             mismatch;
  logic [2*WIDTH:0] err_next;

  // Operands come straight from the registered index; idx holds its last
  // value in IDLE so the adder keeps seeing the final pair after a sweep.
  assign bus.num1 = idx[IDX_W-1:WIDTH];
  assign bus.num2 = idx[WIDTH-1:0];

  always_comb begin
    golden   = {1'b0, bus.num1} + {1'b0, bus.num2};
    mismatch = (golden != {bus.cout_in, bus.sum_in});
    err_next = err_count + {{IDX_W{1'b0}}, mismatch};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      first_valid <= 1'b0;
      first_a     <= '0;
      first_b     <= '0;
      first_sum   <= '0;
      first_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            idx         <= '0;
            busy        <= 1'b1;
            pass        <= 1'b0;
            err_count   <= '0;
            first_valid <= 1'b0;
            first_a     <= '0;
            first_b     <= '0;
            first_sum   <= '0;
            first_cout  <= 1'b0;
          end
        end

        RUN: begin
          err_count <= err_next;
          if (mismatch && !first_valid) begin
            first_valid <= 1'b1;
            first_a     <= bus.num1;
            first_b     <= bus.num2;
            first_sum   <= bus.sum_in;
            first_cout  <= bus.cout_in;
          end
          // The last index is not advanced so num1/num2 rest at all-ones.
          if (idx == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sweep_checker.sv
// tb/tb_add_sweep_checker.sv - directed self-checking bench for add_sweep_checker

module tb_add_sweep_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_count;
  logic       first_valid;
  logic [3:0] first_a;
  logic [3:0] first_b;
  logic [3:0] first_sum;
  logic       first_cout;

  logic [1:0] fault;   // 0 correct adder, 1 carry-in stuck at 1, 2 sum bits 1/3 swapped
  logic [4:0] s5;

  int checks = 0;
  int errors = 0;

  add_sweep_checker_if #(.WIDTH(4)) bus ();

  add_sweep_checker #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .first_valid (first_valid),
    .first_a     (first_a),
    .first_b     (first_b),
    .first_sum   (first_sum),
    .first_cout  (first_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test, with injectable faults.
  always_comb begin
    s5 = {1'b0, bus.num1} + {1'b0, bus.num2};
    case (fault)
      2'd1:    s5 = s5 + 5'd1;
      2'd2:    s5 = {s5[4], s5[1], s5[2], s5[3], s5[0]};
      default: s5 = s5;
    endcase
    bus.sum_in  = s5[3:0];
    bus.cout_in = s5[4];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at the next edge (edge 0 of the sweep).
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts edges after edge 0 until done is seen; n is the edge number.
  task automatic wait_done(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 400 && !ok) begin
      step();
      n++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    fault = 2'd0;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (err_count !== 9'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
    checks++; if (first_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", first_valid); end
    checks++; if ({first_a, first_b, first_sum, first_cout} !== 13'd0) begin errors++; $display("FAIL reset_first got %h want 0", {first_a, first_b, first_sum, first_cout}); end
    checks++; if ({bus.num1, bus.num2} !== 8'd0) begin errors++; $display("FAIL reset_nums got %h want 00", {bus.num1, bus.num2}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_correct();
    int n; bit ok;
    fault = 2'd0;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ok_busy_start got %b want 1", busy); end
    checks++; if ({bus.num1, bus.num2} !== 8'h00) begin errors++; $display("FAIL ok_vec0 got %h want 00", {bus.num1, bus.num2}); end
    wait_done(n, ok);
    checks++; if (!ok || n != 256) begin errors++; $display("FAIL ok_done_edge got %0d want 256", n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ok_busy_done got %b want 1", busy); end
    step();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL ok_idle got busy/done %b want 00", {busy, done}); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ok_pass got %b want 1", pass); end
    checks++; if (err_count !== 9'd0) begin errors++; $display("FAIL ok_err got %0d want 0", err_count); end
    checks++; if (first_valid !== 1'b0) begin errors++; $display("FAIL ok_fv got %b want 0", first_valid); end
    checks++; if ({bus.num1, bus.num2} !== 8'hff) begin errors++; $display("FAIL ok_last_nums got %h want ff", {bus.num1, bus.num2}); end
  endtask

  task automatic test_carry_stuck();
    int n; bit ok;
    fault = 2'd1;
    pulse_start();
    wait_done(n, ok);
    checks++; if (!ok || n != 256) begin errors++; $display("FAIL cin_done_edge got %0d want 256", n); end
    step();
    checks++; if (err_count !== 9'd256) begin errors++; $display("FAIL cin_err got %0d want 256", err_count); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL cin_pass got %b want 0", pass); end
    checks++; if (first_valid !== 1'b1) begin errors++; $display("FAIL cin_fv got %b want 1", first_valid); end
    checks++; if ({first_a, first_b, first_sum, first_cout} !== {4'b0000, 4'b0000, 4'b0001, 1'b0}) begin
      errors++; $display("FAIL cin_first got a=%b b=%b s=%b c=%b want a=0000 b=0000 s=0001 c=0", first_a, first_b, first_sum, first_cout);
    end
  endtask

  task automatic test_bit_swap();
    int n; bit ok;
    int want;
    logic [4:0] t;
    want = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        t = 5'(a + b);
        if (t[1] != t[3]) want++;
      end
    end
    fault = 2'd2;
    pulse_start();
    wait_done(n, ok);
    checks++; if (!ok || n != 256) begin errors++; $display("FAIL swap_done_edge got %0d want 256", n); end
    step();
    checks++; if (err_count !== 9'(want)) begin errors++; $display("FAIL swap_err got %0d want %0d", err_count, want); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL swap_pass got %b want 0", pass); end
    checks++; if ({first_a, first_b, first_sum, first_cout} !== {4'b0000, 4'b0010, 4'b1000, 1'b0}) begin
      errors++; $display("FAIL swap_first got a=%b b=%b s=%b c=%b want a=0000 b=0010 s=1000 c=0", first_a, first_b, first_sum, first_cout);
    end
  endtask

  task automatic test_start_ignored();
    int n; bit ok;
    fault = 2'd0;
    pulse_start();
    n  = 0;
    ok = 1'b0;
    while (n < 400 && !ok) begin
      start = (n == 4 || n == 99);   // sampled at edges 5 and 100
      step();
      n++;
      if (done) ok = 1'b1;
      if (n == 6) begin
        checks++; if ({bus.num1, bus.num2} !== 8'h06) begin errors++; $display("FAIL ign_vec6 got %h want 06", {bus.num1, bus.num2}); end
      end
      if (n == 101) begin
        checks++; if ({bus.num1, bus.num2} !== 8'h65) begin errors++; $display("FAIL ign_vec101 got %h want 65", {bus.num1, bus.num2}); end
      end
    end
    start = 1'b0;
    checks++; if (!ok || n != 256) begin errors++; $display("FAIL ign_done_edge got %0d want 256", n); end
    step();
    checks++; if ({pass, err_count, first_valid} !== {1'b1, 9'd0, 1'b0}) begin
      errors++; $display("FAIL ign_result got pass=%b err=%0d fv=%b want pass=1 err=0 fv=0", pass, err_count, first_valid);
    end
    step();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL ign_no_restart got busy/done %b want 00", {busy, done}); end
  endtask

  task automatic test_reset_mid_sweep();
    int n; bit ok;
    fault = 2'd1;
    pulse_start();
    for (int i = 0; i < 50; i++) step();
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, pass, first_valid} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags got %b want 0000", {busy, done, pass, first_valid}); end
    checks++; if (err_count !== 9'd0) begin errors++; $display("FAIL rst_mid_err got %0d want 0", err_count); end
    checks++; if ({first_a, first_b, first_sum, first_cout, bus.num1, bus.num2} !== 21'd0) begin
      errors++; $display("FAIL rst_mid_data got %h want 0", {first_a, first_b, first_sum, first_cout, bus.num1, bus.num2});
    end
    step();
    rst_n = 1'b1;
    fault = 2'd0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got busy %b want 0", busy); end
    pulse_start();
    wait_done(n, ok);
    checks++; if (!ok || n != 256) begin errors++; $display("FAIL rst_mid_done_edge got %0d want 256", n); end
    step();
    checks++; if ({pass, err_count} !== {1'b1, 9'd0}) begin errors++; $display("FAIL rst_mid_pass got pass=%b err=%0d want 1/0", pass, err_count); end
  endtask

  task automatic test_back_to_back();
    int n; bit ok;
    fault = 2'd1;
    pulse_start();
    wait_done(n, ok);
    checks++; if (!ok || n != 256) begin errors++; $display("FAIL b2b_done1_edge got %0d want 256", n); end
    fault = 2'd0;
    step();
    checks++; if ({busy, pass, err_count, first_valid} !== {1'b0, 1'b0, 9'd256, 1'b1}) begin
      errors++; $display("FAIL b2b_first_result got busy=%b pass=%b err=%0d fv=%b want 0/0/256/1", busy, pass, err_count, first_valid);
    end
    pulse_start();
    checks++; if ({busy, err_count, first_valid, pass} !== {1'b1, 9'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b2b_clear got busy=%b err=%0d fv=%b pass=%b want 1/0/0/0", busy, err_count, first_valid, pass);
    end
    checks++; if ({bus.num1, bus.num2} !== 8'h00) begin errors++; $display("FAIL b2b_vec0 got %h want 00", {bus.num1, bus.num2}); end
    wait_done(n, ok);
    checks++; if (!ok || n != 256) begin errors++; $display("FAIL b2b_done2_edge got %0d want 256", n); end
    step();
    checks++; if ({pass, err_count, first_valid} !== {1'b1, 9'd0, 1'b0}) begin
      errors++; $display("FAIL b2b_pass got pass=%b err=%0d fv=%b want 1/0/0", pass, err_count, first_valid);
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_carry_stuck();
    test_bit_swap();
    test_start_ignored();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_sweep_checker.md
# add_sweep_checker

Self-checking stimulus/response stage wrapped around the 4-bit combinational adder `add`. It sits upstream to drive the adder's `num1`/`num2` operands and downstream to consume its `out`/`cout`. On a start pulse it sweeps every operand pair, compares each result against a golden sum, and reports pass/fail, an error count and the first failing vector. The bench and board bring-up use it to localise faults such as a stuck carry-in or swapped sum bits without hand-written vectors.

## Interface
- `WIDTH`, default 4: operand width; must match the adder under test.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- `num1`  output  WIDTH  operand A to the adder (registered).
- `num2`  output  WIDTH  operand B to the adder (registered).
- `sum_in`  input  WIDTH  adder `out`.
- `cout_in`  input  1  adder `cout`.
- `busy`  output  1  high while the sweep runs.
- `done`  output  1  one-cycle pulse when the sweep finishes.
- `pass`  output  1  high after a sweep with zero mismatches; held until the next start.
- `err_count`  output  2*WIDTH+1  number of mismatching vectors in the last sweep.
- `first_valid`  output  1  high when at least one mismatch has been captured.
- `first_a`, `first_b`  output  WIDTH each  operands of the first mismatch.
- `first_sum`  output  WIDTH  `sum_in` sampled at the first mismatch.
- `first_cout`  output  1  `cout_in` sampled at the first mismatch.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE -> RUN when `start`=1. At that edge:
  - vector index `idx` (2*WIDTH bits) is cleared to 0;
  - `err_count`, `pass`, `first_valid` and all `first_*` outputs are cleared.
- Operands are derived from the index: `num1` = `idx[2*WIDTH-1:WIDTH]`, `num2` = `idx[WIDTH-1:0]`. `num2` is the inner loop.
  - Order is (0,0), (0,1) … (0,15), (1,0) … (15,15).
- RUN, each cycle:
  - Golden value is `num1 + num2` computed at WIDTH+1 bits, with no carry-in.
  - It is compared against `{cout_in, sum_in}`.
  - On mismatch: `err_count` increments. If `first_valid`=0, capture `num1`, `num2`, `sum_in`, `cout_in` and set `first_valid`.
  - `idx` increments. When `idx` = 2^(2*WIDTH)-1 has been checked, go to DONE.
- DONE lasts one cycle:
  - `done`=1;
  - `pass` <= (`err_count`==0), using the final count including the last vector;
  - then return to IDLE.
- `start` asserted during RUN or DONE is ignored and is not queued.
- `err_count` never overflows, because its width holds 2^(2*WIDTH).
- In IDLE, `num1`/`num2` keep their last driven values (15,15 after a full sweep).

## Timing
- Reset values: `num1`=0, `num2`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_valid`=0, `first_a`=`first_b`=`first_sum`=0, `first_cout`=0, state IDLE.
- The adder is combinational. Each operand pair is stable for exactly one full clock, and the result is sampled at the closing edge of that clock.
- Edge numbering, with `start` sampled at edge 0:
  - `busy`=1 from edge 0 through the edge that leaves DONE;
  - vector k is driven between edges k and k+1 and checked at edge k+1;
  - the last vector (255 for WIDTH=4) is checked at edge 256;
  - `done` is high between edges 256 and 257;
  - `busy` falls at edge 257.
- A full sweep takes 2^(2*WIDTH)+1 cycles from `start` to IDLE.
- `rst_n` low mid-sweep immediately returns every output to its reset value. No partial result survives.
- A second `start` in the IDLE cycle after DONE begins a fresh sweep and clears the previous results at that edge.

## Test plan
- **Correct adder model:** `start` -> 256 RUN cycles, `done` pulse at edge 256, `pass`=1, `err_count`=0, `first_valid`=0.
- **Carry-in stuck at 1** (sum = a+b+1): `err_count`=256, `pass`=0, first captured `a`=0000, `b`=0000, `first_sum`=0001, `first_cout`=0.
- **Sum bit 1 wired onto bit 3:** first mismatch at `a`=0000, `b`=0010 with `first_sum`=1000; `err_count` equals the model-computed count of vectors where golden bit 1 != bit 3.
- **Start ignored while busy:** pulse `start` at edges 5 and 100 -> `done` still at edge 256 only, `idx` is not reset, and the result matches a single sweep.
- **Reset mid-sweep:** drop `rst_n` at cycle 50 -> all outputs read reset values immediately; after release and a new `start`, a clean sweep gives `pass`=1.
- **Back-to-back sweeps:** run the faulty model, swap in the correct model, `start` the cycle after `done` -> `err_count` and `first_valid` clear at the start edge and the sweep ends with `pass`=1.
